// File: rtl/pc_gen_unit.sv
// Fetch-stage program counter: sequential advance, branch/JALR redirects, misalignment trap.
// Define PC_GEN_RAS_EN to build the return-address stack used to predict returns.
module pc_gen_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              IMM_SHIFT    = 1,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic                         br_take,
    input  logic [XLEN-1:0]              br_pc,
    input  logic [XLEN-1:0]              br_imm,
    input  logic                         jalr_take,
    input  logic [XLEN-1:0]              jalr_base,
    input  logic [XLEN-1:0]              jalr_imm,
    input  logic                         call,
    input  logic [XLEN-1:0]              call_pc,
    input  logic                         ret,
    input  logic                         trap_clr,
    output logic [XLEN-1:0]              pc,
    output logic                         pc_valid,
    output logic [XLEN-1:0]              target,
    output logic                         misalign_err,
    output logic                         ras_hit,
    output logic [$clog2(RAS_DEPTH):0]   ras_count
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [XLEN-1:0] LSB_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;

    function automatic logic [XLEN-1:0] clr_lsb(input logic [XLEN-1:0] a);
        return a & LSB_MASK;
    endfunction

    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

    state_t          state, state_nxt;
    logic            run;
    logic            redir;
    logic            misal;
    logic            ras_pop;
    logic [XLEN-1:0] redir_tgt;
    logic [XLEN-1:0] ras_top;
    logic [XLEN-1:0] pc_p0;
    logic [XLEN-1:0] target_p0;
    logic            err_p0;
    logic            hit_p0;

    assign run = (state == RUN);

    // Redirect selection: JALR (or predicted return) beats branch
    always_comb begin
        redir     = 1'b0;
        redir_tgt = '0;
        if (jalr_take) begin
            redir     = 1'b1;
            redir_tgt = ras_pop ? ras_top : clr_lsb(jalr_base + jalr_imm);
        end else if (br_take) begin
            redir     = 1'b1;
            redir_tgt = br_pc + (br_imm << IMM_SHIFT);
        end
    end

    assign misal = run & redir & misaligned(redir_tgt[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (misal) state_nxt = TRAP;
            TRAP:    if (trap_clr) state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    always_comb begin
        pc_valid = (state == RUN);
    end

    // Stage p0: PC, redirect target and event pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_p0     <= RESET_VECTOR;
            target_p0 <= '0;
            err_p0    <= 1'b0;
            hit_p0    <= 1'b0;
        end else begin
            err_p0 <= misal;
            hit_p0 <= ras_pop;
            if (run) begin
                if (redir) begin
                    target_p0 <= redir_tgt;
                    if (!misal) pc_p0 <= redir_tgt;
                end else if (!stall) begin
                    pc_p0 <= pc_p0 + XLEN'(4);
                end
            end else if (state == TRAP && trap_clr) begin
                pc_p0 <= TRAP_VECTOR;
            end
        end
    end

    assign pc           = pc_p0;
    assign target       = target_p0;
    assign misalign_err = err_p0;
    assign ras_hit      = hit_p0;

`ifdef PC_GEN_RAS_EN
    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   ras_tp;
    logic [PW-1:0]   ras_nxt;
    logic [CW-1:0]   ras_cnt;

    assign ras_nxt = ras_tp + 1'b1;
    assign ras_top = ras_mem[ras_tp];
    assign ras_pop = run & jalr_take & ret & (ras_cnt != '0);

    // Circular stack: a push when full silently replaces the oldest slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_tp  <= '0;
            ras_cnt <= '0;
        end else if (run) begin
            if (ras_pop && !call) begin
                ras_tp  <= ras_tp - 1'b1;
                ras_cnt <= ras_cnt - 1'b1;
            end else if (call && !ras_pop) begin
                ras_tp <= ras_nxt;
                if (ras_cnt != CW'(RAS_DEPTH)) ras_cnt <= ras_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (run && call) begin
            if (ras_pop) ras_mem[ras_tp]  <= call_pc + XLEN'(4);
            else         ras_mem[ras_nxt] <= call_pc + XLEN'(4);
        end
    end

    assign ras_count = ras_cnt;
`else
    logic unused_ras;
    assign unused_ras = ^{call, call_pc, ret};
    assign ras_top    = '0;
    assign ras_pop    = 1'b0;
    assign ras_count  = '0;
`endif

endmodule

// File: doc/pc_gen_unit.md
# pc_gen_unit

Parametrised program-counter generation unit for the fetch stage. It holds the fetch PC register and advances it sequentially. It computes branch targets (PC + shifted immediate) and JALR targets, and optionally predicts returns with a small return-address stack. It detects misaligned targets and parks in a trap state until the control unit acknowledges, then restarts at a trap vector.

## Interface
- XLEN, 32, datapath/address width (≥ 8)
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap clear
- IMM_SHIFT, 1, left shift applied to the branch immediate before addition (0..2)
- RAS_DEPTH, 4, return-address-stack entries (power of two, ≥ 2)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold PC (no sequential advance)
- br_take  in  1  conditional branch/JAL resolved taken
- br_pc  in  XLEN  PC of the branching instruction
- br_imm  in  XLEN  sign-extended immediate from the immediate generator
- jalr_take  in  1  JALR resolved
- jalr_base  in  XLEN  rs1 value
- jalr_imm  in  XLEN  sign-extended I-immediate
- call  in  1  push request (JAL/JALR with rd=x1/x5)
- call_pc  in  XLEN  PC of the call instruction
- ret  in  1  JALR is a return (qualifies jalr_take)
- trap_clr  in  1  control unit acknowledges trap
- pc  out  XLEN  current fetch PC
- pc_valid  out  1  pc is a legal fetch address this cycle
- target  out  XLEN  last redirect target, registered
- misalign_err  out  1  one-cycle pulse on misaligned redirect
- ras_hit  out  1  one-cycle pulse when a return used the RAS
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries

## Operation
- States: BOOT, RUN, TRAP.
- BOOT: entered on reset; pc = RESET_VECTOR, pc_valid = 0; goes to RUN after one clock.
- RUN: pc_valid = 1. Next PC priority:
  1. jalr_take
  2. br_take
  3. stall (hold)
  4. pc + 4
- A redirect overrides stall.
- Branch target = br_pc + (br_imm << IMM_SHIFT), modulo 2^XLEN; wrap-around is silent.
- JALR target = (jalr_base + jalr_imm) with bit 0 cleared.
- Misaligned target (bit 1 or bit 0 set after the above):
  - misalign_err pulses for one cycle.
  - pc holds its old value.
  - target is still loaded.
  - State goes to TRAP.
- TRAP: pc_valid = 0; all requests ignored. On trap_clr: pc ← TRAP_VECTOR and state goes to RUN.
- Sequential increment past 2^XLEN−4 wraps to 0.
- Reset outputs:
  - pc = RESET_VECTOR, target = 0
  - pc_valid = 0, misalign_err = 0, ras_hit = 0, ras_count = 0
  - state BOOT, RAS pointer 0
- Asserting rst_n low in any state returns immediately to these values.

## Timing
- All outputs are registered. A redirect presented in cycle N appears on pc in cycle N+1.
- Requests are single-cycle strobes sampled only in RUN.
- In BOOT and TRAP, requests are ignored, except trap_clr in TRAP.
- trap_clr in TRAP → pc = TRAP_VECTOR and pc_valid = 1 in the next cycle.

## Configuration
- PC_GEN_RAS_EN defined: RAS compiled in.
  - call pushes call_pc + 4.
  - jalr_take & ret with ras_count > 0:
    - Pops and redirects to the top entry instead of the computed JALR target.
    - ras_hit pulses.
  - jalr_take & ret with an empty RAS uses the computed target.
  - Push when full overwrites the oldest entry; ras_count saturates at RAS_DEPTH.
  - call & ret in the same cycle: pop first, then push. Net count is unchanged; the top entry becomes the new return address.
- PC_GEN_RAS_EN undefined: call and ret are ignored, ras_hit = 0, ras_count = 0, and no RAS storage is built.

## Test plan
- Reset/boot:
  - Drive rst_n low, then release.
  - pc = 0 with pc_valid = 0 for one cycle.
  - Then pc = 0, 4, 8, … with pc_valid = 1.
  - stall high holds pc.
- Branch:
  - br_take with br_pc = 0x40 and br_imm = 0xFFFF_FFF8 (−8), IMM_SHIFT = 1.
  - Next cycle pc = 0x30 and target = 0x30, even with stall high.
- JALR:
  - jalr_base = 0x1001, jalr_imm = 0x10 → pc = 0x1010 (bit 0 cleared).
  - br_take in the same cycle is ignored.
- Misalign/trap:
  - br_pc = 0x100, br_imm = 1 → target = 0x102.
  - misalign_err pulses; pc stays at the old value; pc_valid = 0 until trap_clr.
  - After trap_clr: pc = 0x100 (TRAP_VECTOR).
- RAS (macro defined):
  - Push 5 calls with call_pc = 0x10, 0x20, 0x30, 0x40, 0x50 → ras_count = 4.
  - Four returns yield 0x54, 0x44, 0x34, 0x24, each with ras_hit.
  - A fifth return uses the computed target with ras_hit = 0.
- Async reset mid-TRAP:
  - rst_n low while in TRAP → pc = RESET_VECTOR and ras_count = 0 immediately.
  - BOOT sequence repeats.
